// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side adapter: default word width and
// the occupancy encoding of the two-entry output buffer.
package fifo_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry registered buffer: the head entry drives the output, the second
// entry catches a word that arrives while the head is stalled.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output occ_e             occ,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] skid;
  logic             skid_load;

  // Skid entry fills only when a word lands behind a held head, or refills as it moves up.
  assign skid_load = wr && (((occ == OCC_ONE) && !pop) || ((occ == OCC_TWO) && pop));

  always_ff @(posedge clk) begin
    if (skid_load) skid <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ  <= OCC_EMPTY;
      head <= '0;
    end else begin
      case (occ)
        OCC_EMPTY: begin
          if (wr) begin
            head <= wr_data;
            occ  <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (wr && pop) begin
            head <= wr_data;
          end else if (wr) begin
            occ <= OCC_TWO;
          end else if (pop) begin
            occ <= OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          if (pop) begin
            head <= skid;
            if (!wr) occ <= OCC_ONE;
          end
        end
        default: occ <= OCC_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side adapter for the synchronous FIFO: issues reads on a credit basis,
// absorbs the one-cycle read latency and presents words on a valid/ready stream.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_rd_en,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready,
  output logic [CNT_W-1:0] words_out
);

  occ_e       occ;
  logic       inflight;
  logic       pop;
  logic [1:0] load;

  assign m_valid = (occ != OCC_EMPTY);
  assign pop     = m_valid && m_ready;
  assign load    = 2'(occ) + {1'b0, inflight};

  // A slot freed by this cycle's pop may be reused at once, hence the m_ready path into rd_en.
  assign fifo_rd_en = !rst && en && !fifo_empty &&
                      ((load < 2'd2) || ((load == 2'd2) && pop));

  // Read issued -> FIFO data valid next cycle
  always_ff @(posedge clk) begin
    if (rst) inflight <= 1'b0;
    else     inflight <= fifo_rd_en;
  end

  always_ff @(posedge clk) begin
    if (rst)      words_out <= '0;
    else if (pop) words_out <= words_out + 1'b1;
  end

  // Captured word -> registered output buffer
  fifo_skid_buf #(
    .WIDTH(WIDTH)
  ) u_buf (
    .clk    (clk),
    .rst    (rst),
    .wr     (inflight),
    .wr_data(fifo_data),
    .pop    (pop),
    .occ    (occ),
    .head   (m_data)
  );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural FIFO and a word scoreboard.
module tb_fifo_rd_stream;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [W-1:0]  fifo_data = '0;
  logic          fifo_rd_en;
  logic          m_valid;
  logic [W-1:0]  m_data;
  logic          m_ready = 1'b0;
  logic [CW-1:0] words_out;

  fifo_rd_stream #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd_en(fifo_rd_en),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready),
    .words_out (words_out)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int exp_cnt = 0;
  int rd_cnt = 0;
  int cyc = 0;
  int first_rd_cyc = -1;
  int first_vld_cyc = -1;
  int first_pop_cyc = -1;
  int last_pop_cyc = -1;
  int sec_pops = 0;
  int rd_base = 0;
  logic         hold_valid = 1'b0;
  logic [W-1:0] hold_data = '0;
  logic [W-1:0] fq[$];
  logic [W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [W-1:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic sec_start();
    first_rd_cyc  = -1;
    first_vld_cyc = -1;
    first_pop_cyc = -1;
    last_pop_cyc  = -1;
    sec_pops      = 0;
    rd_base       = rd_cnt;
  endtask

  // One clock cycle: check settled outputs, then model the FIFO across the edge.
  task automatic tick();
    logic         do_rd;
    logic         do_pop;
    logic [W-1:0] e;
    logic [CW-1:0] cnt_lo;
    #1;
    chk("rd_while_empty", 32'(fifo_rd_en && fifo_empty), 32'd0);
    chk("occ_inflight_le2", 32'((int'(dut.occ) + int'(dut.inflight)) <= 2), 32'd1);
    if (hold_valid) chk("m_data_hold", 32'(m_data), 32'(hold_data));
    if (rst) begin
      chk("rd_en_in_rst", 32'(fifo_rd_en), 32'd0);
    end else begin
      cnt_lo = exp_cnt[CW-1:0];
      chk("words_out", 32'(words_out), 32'(cnt_lo));
    end
    if (!rst && m_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
    do_pop = !rst && m_valid && m_ready;
    if (do_pop) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $error("FAIL unexpected_word: observed %0h expected no word", m_data);
      end else begin
        e = exp_q.pop_front();
        chk("m_data", 32'(m_data), 32'(e));
      end
      exp_cnt++;
      sec_pops++;
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
    end
    hold_valid = !rst && m_valid && !m_ready;
    hold_data  = m_data;
    do_rd = !rst && fifo_rd_en;
    if (do_rd) begin
      rd_cnt++;
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      fq.delete();
      exp_q.delete();
      exp_cnt = 0;
      hold_valid = 1'b0;
    end else if (do_rd && fq.size() > 0) begin
      fifo_data = fq.pop_front();
    end
    fifo_empty = (fq.size() == 0);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_words_out", 32'(words_out), 32'd0);

    // Full-rate stream of 0x01..0x08
    en = 1'b1;
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push_word(W'(i));
    sec_start();
    run(12);
    chk("stream_latency", 32'(first_vld_cyc - first_rd_cyc), 32'd2);
    chk("stream_pops", 32'(sec_pops), 32'd8);
    chk("stream_no_gaps", 32'(last_pop_cyc - first_pop_cyc), 32'd7);
    chk("stream_words_out", 32'(words_out), 32'd8);
    chk("stream_drained", 32'(exp_q.size()), 32'd0);

    // Back-pressure with 0x10..0x13
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(W'(8'h10 + i));
    sec_start();
    run(5);
    chk("bp_reads", 32'(rd_cnt - rd_base), 32'd2);
    chk("bp_m_valid", 32'(m_valid), 32'd1);
    chk("bp_m_data", 32'(m_data), 32'h10);
    m_ready = 1'b1;
    sec_start();
    run(8);
    chk("bp_pops", 32'(sec_pops), 32'd4);
    chk("bp_no_gaps", 32'(last_pop_cyc - first_pop_cyc), 32'd3);
    chk("bp_drained", 32'(exp_q.size()), 32'd0);

    // Single word into an empty FIFO
    sec_start();
    run(3);
    chk("empty_idle_reads", 32'(rd_cnt - rd_base), 32'd0);
    push_word(8'hAA);
    run(6);
    chk("empty_one_read", 32'(rd_cnt - rd_base), 32'd1);
    chk("empty_one_pop", 32'(sec_pops), 32'd1);
    chk("empty_drained", 32'(exp_q.size()), 32'd0);

    // Enable dropped with one word buffered and one in flight
    for (int i = 0; i < 4; i++) push_word(W'(8'h20 + i));
    run(2);
    en = 1'b0;
    chk("gate_state_occ", 32'(dut.occ), 32'd1);
    chk("gate_state_inflight", 32'(dut.inflight), 32'd1);
    sec_start();
    run(6);
    chk("gate_no_reads", 32'(rd_cnt - rd_base), 32'd0);
    chk("gate_pops", 32'(sec_pops), 32'd2);
    en = 1'b1;
    sec_start();
    run(1);
    chk("gate_resume", 32'(rd_cnt - rd_base), 32'd1);
    run(6);
    chk("gate_drained", 32'(exp_q.size()), 32'd0);

    // Reset with two words held
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(W'(8'h30 + i));
    run(4);
    chk("pre_rst_occ", 32'(dut.occ), 32'd2);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    chk("post_rst_m_valid", 32'(m_valid), 32'd0);
    chk("post_rst_words_out", 32'(words_out), 32'd0);
    #1;
    chk("post_rst_rd_en", 32'(fifo_rd_en), 32'd0);
    m_ready = 1'b1;
    run(2);

    // Counter wrap: 17 words on a 4-bit counter
    for (int i = 0; i < 17; i++) push_word(W'(8'h40 + i));
    sec_start();
    run(22);
    chk("wrap_pops", 32'(sec_pops), 32'd17);
    chk("wrap_words_out", 32'(words_out), 32'd1);
    chk("wrap_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side adapter for the team's synchronous FIFO. Drives the FIFO's `rd_en`, absorbs its one-cycle read latency, and presents popped words on a registered valid/ready output stream at full throughput. It sits between the FIFO's read port and any downstream consumer that uses valid/ready flow control.

## Interface

- `WIDTH`, 8: data word width; must match the FIFO's `WIDTH`.
- `CNT_W`, 16: width of the delivered-word counter.

Ports:

- `clk` in 1: single clock. One clock; reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: when high, new FIFO reads may be issued. Low stops issuing; buffered and in-flight words still drain.
- `fifo_empty` in 1: FIFO `empty` flag.
- `fifo_data` in WIDTH: FIFO `data_out`, valid in the cycle after a `rd_en` accepted with `!empty`.
- `fifo_rd_en` out 1: FIFO read strobe.
- `m_valid` out 1: output word valid (registered).
- `m_data` out WIDTH: output word (registered).
- `m_ready` in 1: consumer accepts the word when `m_valid && m_ready`.
- `words_out` out CNT_W: count of words delivered (`m_valid && m_ready`); wraps modulo 2^CNT_W.

## Operation

- State: buffer occupancy `occ` ∈ {0, 1, 2} (EMPTY, ONE, TWO), plus a 1-bit `inflight` set in the cycle after a read is issued.
- `pop` = `m_valid && m_ready`.
- `fifo_rd_en` = `!rst && en && !fifo_empty && (occ + inflight < 2 || (occ + inflight == 2 && pop))`.
  - This creates a combinational path from `m_ready` to `fifo_rd_en`. The path is intended.
  - `fifo_rd_en` is never asserted while `fifo_empty` is high.
- Capture: when `inflight` is set, `fifo_data` is written into the buffer in that cycle.
- Ordering:
  - Head entry drives `m_data`; the second entry is a skid slot.
  - Words leave in FIFO order.
- Occupancy transitions, per cycle, using `cap` = `inflight`:
  - `occ_next = occ + cap - pop`.
  - EMPTY→ONE on `cap`.
  - ONE→TWO on `cap && !pop`.
  - ONE→EMPTY on `pop && !cap`.
  - TWO→ONE on `pop && !cap`.
  - `cap && pop` holds the state. In TWO this cannot occur, because the credit rule forbids it.
- Overflow is impossible by construction: `occ + inflight ≤ 2` always. Assert this in verification.
- `m_valid` = (`occ != 0`). `m_data` holds stable while `m_valid && !m_ready`.
- Deasserting `en` mid-stream has no effect on words already in flight.
- `words_out` increments by 1 on each `pop` and wraps from 2^CNT_W−1 to 0.

## Timing

- Reset values:
  - `m_valid` = 0.
  - `m_data` = 0.
  - `words_out` = 0.
  - `occ` = EMPTY.
  - `inflight` = 0.
  - `fifo_rd_en` = 0 during reset.
- Latency: `fifo_rd_en` high in cycle T → `m_valid` high in cycle T+2, with `m_data` equal to the FIFO word read.
- Throughput: with a non-empty FIFO and `m_ready` held high, one word per cycle in steady state (`occ` = 1, `inflight` = 1).
- Back-pressure: `m_ready` low for k cycles stalls the output. At most 2 words are held (one buffered, one captured), and issuing stops until a `pop`.
- Reset asserted mid-operation:
  - Buffered words and any in-flight read are discarded.
  - Outputs return to reset values on the next edge.
  - The FIFO is reset by the same `rst`, so no word is lost relative to FIFO state.
- `fifo_empty` rising in the same cycle as a potential read: no read is issued, and `inflight` stays 0.

## Structure

- Shared package `fifo_pkg`:
  - Default `WIDTH`.
  - Occupancy enum `occ_e` {OCC_EMPTY, OCC_ONE, OCC_TWO}.
- One sub-module `fifo_skid_buf`: a 2-entry registered buffer with a `wr`/`pop` interface and head output.
- `fifo_rd_stream` holds the credit logic, `inflight`, and `words_out`.

## Test plan

- Stream: FIFO preloaded with 0x01..0x08, `en`=1, `m_ready`=1 → first `m_valid` 2 cycles after the first `fifo_rd_en`; 8 consecutive cycles deliver 0x01..0x08; `words_out`=8.
- Back-pressure: FIFO holds 0x10..0x13, `m_ready` low for 5 cycles → exactly 2 reads issued, `m_data`=0x10 stable; on release, 0x10..0x13 arrive in order with no gaps after the first.
- Empty boundary: a single word 0xAA is written into an empty FIFO → exactly one `fifo_rd_en` pulse; 0xAA is delivered; `fifo_rd_en` never high while `fifo_empty`=1.
- Enable gating: drop `en` while one read is in flight and `occ`=1 → both words (2) are still delivered, no further reads; raising `en` resumes reads next cycle.
- Reset mid-stream: assert `rst` for 1 cycle with `occ`=2 → next cycle `m_valid`=0, `words_out`=0, `fifo_rd_en`=0.
- Counter wrap: `CNT_W`=4, deliver 17 words → `words_out`=1.
